// File: rtl/byte_serial_add_ctrl_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer:
// FSM state encodings, default operand size, index-width helper and
// the 4-bit ripple primitive used by the carry-select slice.
package byte_serial_add_ctrl_pkg;

  localparam int NBYTES_DEF = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Width of the byte index counter; never narrower than one bit so that
  // a single-byte configuration still has a legal (constant-zero) index.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

  // 4-bit ripple adder, returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] ripple4(input logic [3:0] x,
                                         input logic [3:0] y,
                                         input logic       c);
    logic       c_v;
    logic [3:0] s_v;
    c_v = c;
    s_v = 4'h0;
    for (int i = 0; i < 4; i++) begin
      s_v[i] = x[i] ^ y[i] ^ c_v;
      c_v    = (x[i] & y[i]) | (c_v & (x[i] ^ y[i]));
    end
    return {c_v, s_v};
  endfunction

endpackage

// File: rtl/csa8_slice.sv
// Combinational 8-bit carry-select adder slice. Each nibble is computed
// twice (carry-in 0 and 1) and the real carry picks the result, so the
// critical path is one nibble ripple plus two mux levels.
module csa8_slice
  import byte_serial_add_ctrl_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [4:0] lo0_s;
  logic [4:0] lo1_s;
  logic [4:0] hi0_s;
  logic [4:0] hi1_s;
  logic [4:0] lo_sel_s;
  logic [4:0] hi_sel_s;

  assign lo0_s = ripple4(a[3:0], b[3:0], 1'b0);
  assign lo1_s = ripple4(a[3:0], b[3:0], 1'b1);
  assign hi0_s = ripple4(a[7:4], b[7:4], 1'b0);
  assign hi1_s = ripple4(a[7:4], b[7:4], 1'b1);

  // Select nibble results with the incoming and intermediate carries.
  always_comb begin
    lo_sel_s = 5'h00;
    hi_sel_s = 5'h00;
    if (cin) begin
      lo_sel_s = lo1_s;
    end else begin
      lo_sel_s = lo0_s;
    end
    if (lo_sel_s[4]) begin
      hi_sel_s = hi1_s;
    end else begin
      hi_sel_s = hi0_s;
    end
  end

  assign sum  = {hi_sel_s[3:0], lo_sel_s[3:0]};
  assign cout = hi_sel_s[4];

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial add/subtract sequencer around one shared csa8_slice.
// Operands are captured on accept (B pre-inverted for subtraction), then
// processed LSB byte first, one byte per clock. The result is built in a
// working register and only copied to the output register on the last
// byte, so an aborted operation never exposes a partial sum.
module byte_serial_add_ctrl
  import byte_serial_add_ctrl_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8*NBYTES-1:0] in_a,
  input  logic [8*NBYTES-1:0] in_b,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*NBYTES-1:0] out_sum,
  output logic              out_cout,
  output logic              out_ovf,
  output logic              busy
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = idx_width(NBYTES);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [IDXW-1:0] idx_r;
  logic            carry_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    work_r;
  logic [W-1:0]    sum_r;
  logic            cout_r;
  logic            ovf_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            busy_r;

  logic [7:0]      a_byte_s;
  logic [7:0]      b_byte_s;
  logic [7:0]      slice_sum_s;
  logic            slice_cout_s;
  logic [W-1:0]    merged_s;
  logic            last_s;

  assign last_s = (idx_r == IDX_LAST);

  // Select the operand byte addressed by the current index.
  always_comb begin
    a_byte_s = 8'h00;
    b_byte_s = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      a_byte_s = (idx_r == IDXW'(i)) ? a_r[i*8 +: 8] : a_byte_s;
      b_byte_s = (idx_r == IDXW'(i)) ? b_r[i*8 +: 8] : b_byte_s;
    end
  end

  csa8_slice u_slice (
    .a    (a_byte_s),
    .b    (b_byte_s),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // Working result with the freshly computed byte dropped into place.
  always_comb begin
    merged_s = work_r;
    for (int i = 0; i < NBYTES; i++) begin
      merged_s[i*8 +: 8] = (idx_r == IDXW'(i)) ? slice_sum_s : work_r[i*8 +: 8];
    end
  end

  // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    state_nxt_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register plus handshake flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == S_IDLE);
      out_valid_r <= (state_nxt_s == S_DONE);
      busy_r      <= (state_nxt_s != S_IDLE);
    end
  end

  // Operand capture, per-byte accumulation and final result latching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      work_r  <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            a_r     <= in_a;
            b_r     <= in_b ^ {W{in_sub}};
            idx_r   <= '0;
            carry_r <= in_sub;
            work_r  <= '0;
          end
        end
        S_RUN: begin
          work_r  <= merged_s;
          carry_r <= slice_cout_s;
          if (last_s) begin
            sum_r  <= merged_s;
            cout_r <= slice_cout_s;
            ovf_r  <= (a_r[W-1] == b_r[W-1]) && (slice_sum_s[7] != a_r[W-1]);
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_sum   = sum_r;
  assign out_cout  = cout_r;
  assign out_ovf   = ovf_r;

endmodule
